// File: rtl/seq_delay_checker_pkg.sv
// rtl/seq_delay_checker_pkg.sv - shared types and limits for the a ##DLY b checker
package seq_chk_pkg;

    typedef enum logic [1:0] {OFF, ON, DRAIN} chk_state_t;

    localparam int DLY_MAX = 32;

    function automatic bit dly_legal(input int dly);
        return (dly >= 1) && (dly <= DLY_MAX);
    endfunction

endpackage

// File: rtl/seq_delay_checker_if.sv
// rtl/seq_delay_checker_if.sv - control, sample and result bundle for seq_delay_checker
interface seq_delay_checker_if #(parameter int CNT_W = 16);
    logic             en;
    logic             kill;
    logic             cnt_clr;
    logic             a;
    logic             b;
    logic             pass;
    logic             fail;
    logic             busy;
    logic [CNT_W-1:0] pass_cnt;
    logic [CNT_W-1:0] fail_cnt;

    modport master (
        output en, kill, cnt_clr, a, b,
        input  pass, fail, busy, pass_cnt, fail_cnt
    );

    modport slave (
        input  en, kill, cnt_clr, a, b,
        output pass, fail, busy, pass_cnt, fail_cnt
    );
endinterface

// File: rtl/seq_delay_checker_sat_counter.sv
// rtl/seq_delay_checker_sat_counter.sv - saturating event counter with synchronous clear
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    // Clear beats increment so the edge that clears is never counted.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seq_delay_checker.sv
// rtl/seq_delay_checker.sv - on-chip checker for a ##DLY b with on/drain/kill control
module seq_delay_checker
    import seq_chk_pkg::*;
#(
    parameter int DLY   = 2,
    parameter int CNT_W = 16
) (
    input logic                clk,
    input logic                rst,
    seq_delay_checker_if.slave bus
);

    generate
        if (!dly_legal(DLY)) begin : g_dly_check
            $error("seq_delay_checker: DLY out of range 1..32");
        end
    endgenerate

    logic [DLY-1:0]   pend;
    logic [DLY-1:0]   shifted;
    logic [DLY-1:0]   pend_next;
    logic             start;
    logic             resolve;
    logic             pass_q;
    logic             fail_q;
    logic             busy_q;
    logic [CNT_W-1:0] pass_cnt;
    logic [CNT_W-1:0] fail_cnt;
    chk_state_t       state;
    chk_state_t       state_next;

    assign start   = bus.en & bus.a & ~bus.kill;
    // Kill suppresses the attempt that would otherwise resolve this edge.
    assign resolve = pend[DLY-1] & ~bus.kill;

    generate
        if (DLY == 1) begin : g_shift_one
            assign shifted = start;
        end else begin : g_shift_many
            assign shifted = {pend[DLY-2:0], start};
        end
    endgenerate

    assign pend_next = bus.kill ? '0 : shifted;

    always_ff @(posedge clk) begin
        if (rst) begin
            pend   <= '0;
            state  <= OFF;
            pass_q <= 1'b0;
            fail_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            pend   <= pend_next;
            state  <= state_next;
            pass_q <= resolve & bus.b;
            fail_q <= resolve & ~bus.b;
            busy_q <= |pend_next;
        end
    end

    always_comb begin
        state_next = state;
        if (bus.kill) begin
            state_next = bus.en ? ON : OFF;
        end else begin
            case (state)
                OFF:     state_next = bus.en ? ON : OFF;
                ON:      state_next = bus.en ? ON : ((|pend_next) ? DRAIN : OFF);
                DRAIN:   state_next = bus.en ? ON : ((|pend_next) ? DRAIN : OFF);
                default: state_next = OFF;
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_pass_cnt (
        .clk (clk),
        .rst (rst),
        .clr (bus.cnt_clr),
        .inc (resolve & bus.b),
        .cnt (pass_cnt)
    );

    sat_counter #(.W(CNT_W)) u_fail_cnt (
        .clk (clk),
        .rst (rst),
        .clr (bus.cnt_clr),
        .inc (resolve & ~bus.b),
        .cnt (fail_cnt)
    );

    assign bus.pass     = pass_q;
    assign bus.fail     = fail_q;
    assign bus.busy     = busy_q;
    assign bus.pass_cnt = pass_cnt;
    assign bus.fail_cnt = fail_cnt;

endmodule

// File: tb/tb_seq_delay_checker.sv
// tb/tb_seq_delay_checker.sv - directed self-checking bench for seq_delay_checker
module tb_seq_delay_checker;
    import seq_chk_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    seq_delay_checker_if #(.CNT_W(16)) bus0 ();
    seq_delay_checker_if #(.CNT_W(3))  bus1 ();

    seq_delay_checker #(.DLY(2), .CNT_W(16)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
    seq_delay_checker #(.DLY(2), .CNT_W(3))  dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus0.en = 0; bus0.kill = 0; bus0.cnt_clr = 0; bus0.a = 0; bus0.b = 0;
        bus1.en = 0; bus1.kill = 0; bus1.cnt_clr = 0; bus1.a = 0; bus1.b = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus0.pass !== 1'b0) $display("FAIL reset_pass act=%b exp=0", bus0.pass); else passed++;
        checks++; if (bus0.fail !== 1'b0) $display("FAIL reset_fail act=%b exp=0", bus0.fail); else passed++;
        checks++; if (bus0.busy !== 1'b0) $display("FAIL reset_busy act=%b exp=0", bus0.busy); else passed++;
        checks++; if (bus0.pass_cnt !== 16'd0) $display("FAIL reset_pass_cnt act=%0d exp=0", bus0.pass_cnt); else passed++;
        checks++; if (bus0.fail_cnt !== 16'd0) $display("FAIL reset_fail_cnt act=%0d exp=0", bus0.fail_cnt); else passed++;
        checks++; if (dut0.state !== OFF) $display("FAIL reset_state act=%0d exp=%0d", dut0.state, OFF); else passed++;
    endtask

    task automatic test_single();
        do_reset();
        bus0.en = 1; bus0.a = 1; bus0.b = 0; tick();
        checks++; if (dut0.state !== ON) $display("FAIL single_state1 act=%0d exp=%0d", dut0.state, ON); else passed++;
        bus0.a = 0; tick();
        checks++; if (bus0.pass !== 1'b0) $display("FAIL single_pass2 act=%b exp=0", bus0.pass); else passed++;
        bus0.b = 1; tick();
        checks++; if (bus0.pass !== 1'b1) $display("FAIL single_pass3 act=%b exp=1", bus0.pass); else passed++;
        checks++; if (bus0.fail !== 1'b0) $display("FAIL single_fail3 act=%b exp=0", bus0.fail); else passed++;
        checks++; if (bus0.pass_cnt !== 16'd1) $display("FAIL single_pass_cnt act=%0d exp=1", bus0.pass_cnt); else passed++;
        checks++; if (bus0.fail_cnt !== 16'd0) $display("FAIL single_fail_cnt act=%0d exp=0", bus0.fail_cnt); else passed++;
        bus0.b = 0; tick();
        checks++; if (bus0.pass !== 1'b0) $display("FAIL single_pass4 act=%b exp=0", bus0.pass); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [1:8] a_v    = 8'b1111_1000;
        logic [1:8] b_v    = 8'b0011_0110;
        logic [1:8] pass_v = 8'b0011_0110;
        logic [1:8] fail_v = 8'b0000_1000;
        logic [1:8] busy_v = 8'b1111_1100;
        do_reset();
        bus0.en = 1;
        for (int e = 1; e <= 8; e++) begin
            bus0.a = a_v[e];
            bus0.b = b_v[e];
            tick();
            checks++; if (bus0.pass !== pass_v[e]) $display("FAIL b2b_pass edge=%0d act=%b exp=%b", e, bus0.pass, pass_v[e]); else passed++;
            checks++; if (bus0.fail !== fail_v[e]) $display("FAIL b2b_fail edge=%0d act=%b exp=%b", e, bus0.fail, fail_v[e]); else passed++;
            checks++; if (bus0.busy !== busy_v[e]) $display("FAIL b2b_busy edge=%0d act=%b exp=%b", e, bus0.busy, busy_v[e]); else passed++;
        end
        checks++; if (bus0.pass_cnt !== 16'd4) $display("FAIL b2b_pass_cnt act=%0d exp=4", bus0.pass_cnt); else passed++;
        checks++; if (bus0.fail_cnt !== 16'd1) $display("FAIL b2b_fail_cnt act=%0d exp=1", bus0.fail_cnt); else passed++;
    endtask

    // Runs straight after back_to_back so the counters are non-zero when rst hits.
    task automatic test_rst_mid();
        idle_inputs();
        bus0.en = 1; bus0.a = 1; tick();
        checks++; if (bus0.busy !== 1'b1) $display("FAIL rstmid_busy1 act=%b exp=1", bus0.busy); else passed++;
        rst = 1; tick();
        rst = 0;
        checks++; if (bus0.pass !== 1'b0) $display("FAIL rstmid_pass act=%b exp=0", bus0.pass); else passed++;
        checks++; if (bus0.fail !== 1'b0) $display("FAIL rstmid_fail act=%b exp=0", bus0.fail); else passed++;
        checks++; if (bus0.busy !== 1'b0) $display("FAIL rstmid_busy act=%b exp=0", bus0.busy); else passed++;
        checks++; if (bus0.pass_cnt !== 16'd0) $display("FAIL rstmid_pass_cnt act=%0d exp=0", bus0.pass_cnt); else passed++;
        checks++; if (bus0.fail_cnt !== 16'd0) $display("FAIL rstmid_fail_cnt act=%0d exp=0", bus0.fail_cnt); else passed++;
        bus0.a = 0; bus0.b = 1;
        for (int e = 3; e <= 4; e++) begin
            tick();
            checks++; if ({bus0.pass, bus0.fail} !== 2'b00) $display("FAIL rstmid_result edge=%0d act=%b exp=00", e, {bus0.pass, bus0.fail}); else passed++;
        end
    endtask

    task automatic test_drain();
        do_reset();
        bus0.en = 1; bus0.a = 1; tick();
        checks++; if (dut0.state !== ON) $display("FAIL drain_state1 act=%0d exp=%0d", dut0.state, ON); else passed++;
        bus0.en = 0; tick();
        checks++; if (dut0.state !== DRAIN) $display("FAIL drain_state2 act=%0d exp=%0d", dut0.state, DRAIN); else passed++;
        checks++; if (bus0.busy !== 1'b1) $display("FAIL drain_busy2 act=%b exp=1", bus0.busy); else passed++;
        bus0.a = 0; bus0.b = 1; tick();
        checks++; if (bus0.pass !== 1'b1) $display("FAIL drain_pass3 act=%b exp=1", bus0.pass); else passed++;
        checks++; if (dut0.state !== OFF) $display("FAIL drain_state3 act=%0d exp=%0d", dut0.state, OFF); else passed++;
        checks++; if (bus0.busy !== 1'b0) $display("FAIL drain_busy3 act=%b exp=0", bus0.busy); else passed++;
        tick();
        checks++; if ({bus0.pass, bus0.fail} !== 2'b00) $display("FAIL drain_result4 act=%b exp=00", {bus0.pass, bus0.fail}); else passed++;
        checks++; if (bus0.pass_cnt !== 16'd1) $display("FAIL drain_pass_cnt act=%0d exp=1", bus0.pass_cnt); else passed++;
    endtask

    task automatic test_kill();
        do_reset();
        bus0.en = 1; bus0.b = 1;
        bus0.a = 1; tick();
        tick();
        bus0.kill = 1; tick();
        bus0.kill = 0;
        checks++; if ({bus0.pass, bus0.fail} !== 2'b00) $display("FAIL kill_result3 act=%b exp=00", {bus0.pass, bus0.fail}); else passed++;
        checks++; if (bus0.busy !== 1'b0) $display("FAIL kill_busy3 act=%b exp=0", bus0.busy); else passed++;
        checks++; if (dut0.state !== ON) $display("FAIL kill_state3 act=%0d exp=%0d", dut0.state, ON); else passed++;
        bus0.a = 0;
        for (int e = 4; e <= 5; e++) begin
            tick();
            checks++; if ({bus0.pass, bus0.fail} !== 2'b00) $display("FAIL kill_result edge=%0d act=%b exp=00", e, {bus0.pass, bus0.fail}); else passed++;
        end
        checks++; if (bus0.pass_cnt !== 16'd0) $display("FAIL kill_pass_cnt act=%0d exp=0", bus0.pass_cnt); else passed++;
        checks++; if (bus0.fail_cnt !== 16'd0) $display("FAIL kill_fail_cnt act=%0d exp=0", bus0.fail_cnt); else passed++;
    endtask

    task automatic test_saturate_clear();
        logic [2:0] exp_cnt;
        logic       exp_pass;
        do_reset();
        bus1.en = 1; bus1.b = 1;
        for (int e = 1; e <= 12; e++) begin
            bus1.a       = (e <= 9);
            bus1.cnt_clr = (e == 11);
            tick();
            exp_pass = (e >= 3) && (e <= 11);
            if (e < 3)        exp_cnt = 3'd0;
            else if (e <= 9)  exp_cnt = 3'(e - 2);
            else if (e == 10) exp_cnt = 3'd7;
            else              exp_cnt = 3'd0;
            if (e >= 8) begin
                checks++; if (bus1.pass_cnt !== exp_cnt) $display("FAIL sat_pass_cnt edge=%0d act=%0d exp=%0d", e, bus1.pass_cnt, exp_cnt); else passed++;
                checks++; if (bus1.pass !== exp_pass) $display("FAIL sat_pass edge=%0d act=%b exp=%b", e, bus1.pass, exp_pass); else passed++;
            end
        end
        checks++; if (bus1.fail_cnt !== 3'd0) $display("FAIL sat_fail_cnt act=%0d exp=0", bus1.fail_cnt); else passed++;
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single();
        test_back_to_back();
        test_rst_mid();
        test_drain();
        test_kill();
        test_saturate_clear();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/seq_delay_checker.md
# seq_delay_checker

Synthesizable checker for the concurrent property `a ##DLY b`, sampled on the rising edge of `clk`. One attempt starts on every sampled edge where the checker is enabled and `a` is high, so attempts may overlap. Each attempt resolves exactly DLY edges later as a pass or a fail. The block is the on-chip counterpart of the team's simulation assertions, with run-time on/drain/kill control equivalent to `$asserton`, `$assertoff` and `$assertkill`. It sits beside the datapath it monitors and reports results as pulses and counts.

## Interface
- DLY, 2, cycle delay between `a` and `b`; legal range 1..32.
- CNT_W, 16, width of the pass and fail counters.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  allows new attempts to start; 0 stops new attempts, and attempts already in flight still complete.
- kill  in  1  discards all in-flight attempts and blocks a new start at the same edge.
- cnt_clr  in  1  clears `pass_cnt` and `fail_cnt`.
- a  in  1  antecedent.
- b  in  1  consequent.
- pass  out  1  one-cycle pulse per passing attempt.
- fail  out  1  one-cycle pulse per failing attempt.
- busy  out  1  at least one attempt is in flight.
- pass_cnt  out  CNT_W  saturating count of passes.
- fail_cnt  out  CNT_W  saturating count of fails.

## Operation
- Pending attempts are held in a shift register `pend[DLY-1:0]`. Each edge loads `pend[0] <= en & a & ~kill` and shifts the register by one position.
- The attempt leaving `pend[DLY-1]` resolves at that edge against the sampled `b`:
  - `b` = 1 gives `pass`.
  - `b` = 0 gives `fail`.
- Vacuous edges (`a` = 0 or `en` = 0) start nothing and produce neither pass nor fail.
- Control FSM states:
  - OFF: `en` = 0 and nothing pending.
  - ON: `en` = 1.
  - DRAIN: `en` = 0 and `pend` non-zero.
- FSM transitions:
  - OFF→ON on `en`.
  - ON→DRAIN on `!en && |pend_next`.
  - ON→OFF on `!en && pend_next == 0`.
  - DRAIN→OFF when `pend_next == 0`.
  - DRAIN→ON on `en`.
  - `kill` from any state: next state is ON if `en`, otherwise OFF.
- `busy` is registered and equals `|pend`.
- `kill` at edge k zeroes `pend`. An attempt that would resolve at k produces no pass/fail and is not counted; `kill` wins over resolution.
- Counters increment by 1 on their pulse and saturate at 2^CNT_W−1.
  - `cnt_clr` wins over an increment at the same edge: the count becomes 0 and that edge's result is not counted.
  - The `pass`/`fail` pulse still fires when `cnt_clr` is high.
- `pass` and `fail` are mutually exclusive; each edge resolves at most one attempt.

## Timing
- Reset values: `pend` = 0, state OFF, `pass` = 0, `fail` = 0, `busy` = 0, `pass_cnt` = 0, `fail_cnt` = 0.
- `rst` mid-operation drops all pending attempts with no pass/fail. `rst` has priority over `kill`, `cnt_clr` and `en`.
- Latency: `a` sampled at edge k → `pass`/`fail` is high in the cycle after edge k+DLY, and the counter has its updated value in that same cycle.
- Back-to-back: `a` held high for N edges with `en` = 1 gives N consecutive results.
- `en` falling at edge k: the last attempt that can start is at edge k−1, and results continue to edge k−1+DLY.
- DLY = 1: `pend` is a single flop. Behaviour otherwise unchanged.

## Structure
- Package `seq_chk_pkg`:
  - `typedef enum logic [1:0] {OFF, ON, DRAIN} chk_state_t`.
  - `localparam DLY_MAX = 32`.
  - Elaboration check on DLY.
- Sub-module `sat_counter` (parameter W; ports clk, rst, clr, inc, cnt), instantiated twice.

## Test plan
- DLY = 2, `en` = 1. `a` = 1 at edge 1 only, `b` = 1 at edge 3 → single `pass` after edge 3; `pass_cnt` = 1, `fail_cnt` = 0.
- `a` = 1 at edges 1–5, `b` = 1 at edges 3, 4, 6, 7, `b` = 0 at edge 5 → results in order pass, pass, fail, pass, pass; `pass_cnt` = 4, `fail_cnt` = 1; `busy` stays high from after edge 1 through edge 7.
- `a` = 1 at edges 1–2, `en` falls at edge 2 → one attempt resolves at edge 3; state is ON→DRAIN→OFF; no result at edge 4.
- `a` = 1 at edges 1–3, `kill` at edge 3 → no pass/fail at edges 3–5; counters unchanged; `busy` = 0 after edge 3.
- CNT_W = 3, eight consecutive passes → `pass_cnt` holds at 7. Then `cnt_clr` asserted at the same edge as a pass → `pass_cnt` = 0 and the `pass` pulse still fires.
- `rst` at edge 2 with attempts pending → every output is 0 after edge 2, and no result appears at edges 3–4.
